// File: rtl/bit_serial_collector_pkg.sv
// rtl/bit_serial_collector_pkg.sv - shared types, defaults and lane mapping for the collector
package bit_serial_collector_pkg;

  localparam int WIDTH_DEF        = 16;
  localparam int LANES_PER_PE_DEF = 4;
  localparam int NUM_PE_DEF       = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Same mapping the slicer uses to fan lanes out to the PEs.
  function automatic int lane_index(input int pe, input int k, input int lanes_per_pe);
    return pe * lanes_per_pe + k;
  endfunction

endpackage

// File: rtl/bit_serial_collector_if.sv
// rtl/bit_serial_collector_if.sv - PE bit-vector input and result packet handshake bundle
interface bit_serial_collector_if
  import bit_serial_collector_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int LANES_PER_PE = LANES_PER_PE_DEF,
  parameter int NUM_PE       = NUM_PE_DEF
) ();

  localparam int CW = $clog2(WIDTH);

  logic                             start;
  logic                             in_valid;
  logic [LANES_PER_PE-1:0]          pe1_o_vec_bits;
  logic [LANES_PER_PE-1:0]          pe2_o_vec_bits;
  logic [CW-1:0]                    bit_counter;
  logic                             busy;
  logic                             out_valid;
  logic                             out_ready;
  logic [NUM_PE*LANES_PER_PE*WIDTH-1:0] result_data;

  modport master (
    output start, in_valid, pe1_o_vec_bits, pe2_o_vec_bits, out_ready,
    input  bit_counter, busy, out_valid, result_data
  );

  modport slave (
    input  start, in_valid, pe1_o_vec_bits, pe2_o_vec_bits, out_ready,
    output bit_counter, busy, out_valid, result_data
  );

endinterface

// File: rtl/bit_serial_collector_lane_shift_reg.sv
// rtl/bit_serial_collector_lane_shift_reg.sv - one lane's MSB-first serial-in word register
module lane_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= {q[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/bit_serial_collector.sv
// rtl/bit_serial_collector.sv - gathers serial PE result bits into an 8-lane word packet
module bit_serial_collector
  import bit_serial_collector_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int LANES_PER_PE = LANES_PER_PE_DEF,
  parameter int NUM_PE       = NUM_PE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  bit_serial_collector_if.slave bus
);

  localparam int CW    = $clog2(WIDTH);
  localparam int LANES = NUM_PE * LANES_PER_PE;
  localparam logic [CW-1:0] LAST_BEAT = CW'(WIDTH - 1);

  state_t                 state_q, state_n;
  logic [CW-1:0]          cnt_q, cnt_n;
  logic                   clr;
  logic                   shift_en;
  logic [LANES*WIDTH-1:0] words;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    clr      = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_n = COLLECT;
          cnt_n   = '0;
          clr     = 1'b1;
        end
      end
      COLLECT: begin
        if (bus.in_valid) begin
          shift_en = 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_n = DONE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        // Taking a start together with the handshake skips IDLE entirely.
        if (bus.out_ready) begin
          if (bus.start) begin
            state_n = COLLECT;
            cnt_n   = '0;
            clr     = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  for (genvar pe = 0; pe < NUM_PE; pe++) begin : g_pe
    for (genvar k = 0; k < LANES_PER_PE; k++) begin : g_lane
      localparam int L = lane_index(pe, k, LANES_PER_PE);
      logic sin;
      if (pe == 0) begin : g_pe1
        assign sin = bus.pe1_o_vec_bits[k];
      end else begin : g_pe2
        assign sin = bus.pe2_o_vec_bits[k];
      end
      lane_shift_reg #(.WIDTH(WIDTH)) u_sr (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (shift_en),
        .din (sin),
        .q   (words[L*WIDTH +: WIDTH])
      );
    end
  end

  assign bus.result_data = words;
  assign bus.bit_counter = cnt_q;
  assign bus.busy        = (state_q == COLLECT);
  assign bus.out_valid   = (state_q == DONE);

endmodule

// File: tb/tb_bit_serial_collector.sv
// tb/tb_bit_serial_collector.sv - self-checking bench for bit_serial_collector
module tb_bit_serial_collector;

  typedef struct {
    logic [127:0] words;
    logic [15:0]  stall;
    int           lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit_serial_collector_if bus ();

  bit_serial_collector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] model_word [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int n = 0; n < 8; n++) model_word[n] = 16'h0;
  endtask

  // Word value = sum of received bits weighted MSB-first.
  task automatic model_beat(input logic [7:0] bits);
    for (int n = 0; n < 8; n++)
      model_word[n] = 16'((int'(model_word[n]) * 2 + int'(bits[n])) % 65536);
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    for (int n = 0; n < 8; n++) f[n*16 +: 16] = model_word[n];
    return f;
  endfunction

  task automatic drive_beat(input logic [127:0] words, input int i);
    logic [7:0] bits;
    for (int n = 0; n < 8; n++) bits[n] = words[n*16 + 15 - i];
    bus.pe1_o_vec_bits = bits[3:0];
    bus.pe2_o_vec_bits = bits[7:4];
    bus.in_valid = 1'b1;
    model_beat(bits);
  endtask

  task automatic feed(input logic [127:0] words, input int first, input logic [15:0] stall,
                      output int edges);
    int beat;
    int c;
    logic [3:0] prev;
    beat  = first;
    c     = 0;
    edges = 0;
    while (beat < 16 && c < 64) begin
      if (c < 16 && stall[c]) begin
        bus.in_valid       = 1'b0;
        bus.pe1_o_vec_bits = 4'($urandom);
        bus.pe2_o_vec_bits = 4'($urandom);
        prev = bus.bit_counter;
        tick();
        edges++;
        chk("stall_counter_hold", 128'(bus.bit_counter), 128'(prev));
      end else begin
        drive_beat(words, beat);
        tick();
        edges++;
        beat++;
        if (beat < 16) begin
          chk("beat_counter", 128'(bus.bit_counter), 128'(beat));
          chk("no_early_valid", 128'(bus.out_valid), 128'(0));
        end else begin
          chk("valid_after_last", 128'(bus.out_valid), 128'(1));
          chk("counter_wrap", 128'(bus.bit_counter), 128'(0));
          chk("busy_low_done", 128'(bus.busy), 128'(0));
        end
      end
      c++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    model_clear();
    chk("busy_after_start", 128'(bus.busy), 128'(1));
    chk("clear_on_start", bus.result_data, 128'(0));
  endtask

  task automatic handshake();
    logic [127:0] held;
    held = bus.result_data;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("valid_drop", 128'(bus.out_valid), 128'(0));
    chk("idle_busy", 128'(bus.busy), 128'(0));
    chk("data_kept", bus.result_data, held);
  endtask

  vec_t tv [5];
  logic [127:0] pkt1;
  logic [127:0] held;
  int edges;

  initial begin
    pkt1 = {16'hAAAA, 16'h5555, 16'hABCD, 16'h1234, 16'h0000, 16'hFFFF, 16'h7FFE, 16'h8001};
    tv[0] = '{pkt1, 16'h0000, 17};
    tv[1] = '{pkt1, 16'h0418, 20};
    tv[2] = '{{8{16'h00FF}}, 16'h0000, 17};
    tv[3] = '{{$urandom, $urandom, $urandom, $urandom}, 16'($urandom & 32'h0000_2211), 0};
    tv[4] = '{{$urandom, $urandom, $urandom, $urandom}, 16'($urandom & 32'h0000_8421), 0};
    for (int i = 3; i < 5; i++) tv[i].lat = 17 + $countones(tv[i].stall);

    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.pe1_o_vec_bits = 4'h0;
    bus.pe2_o_vec_bits = 4'h0;
    model_clear();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_counter", 128'(bus.bit_counter), 128'(0));
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_data", bus.result_data, 128'(0));

    // in_valid without start must not leave IDLE
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.pe1_o_vec_bits = 4'hF;
      bus.pe2_o_vec_bits = 4'hF;
      tick();
      chk("idle_ignore_busy", 128'(bus.busy), 128'(0));
      chk("idle_ignore_data", bus.result_data, 128'(0));
    end
    bus.in_valid = 1'b0;

    for (int t = 0; t < 5; t++) begin
      do_start();
      feed(tv[t].words, 0, tv[t].stall, edges);
      chk("latency", 128'(edges + 1), 128'(tv[t].lat));
      chk("words_vs_model", bus.result_data, model_flat());
      chk("words_vs_table", bus.result_data, tv[t].words);
      handshake();
    end

    // DONE hold with out_ready low, random in_valid traffic and start
    do_start();
    feed(pkt1, 0, 16'h0, edges);
    held = bus.result_data;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'($urandom);
      bus.pe1_o_vec_bits = 4'($urandom);
      bus.pe2_o_vec_bits = 4'($urandom);
      bus.start = (i == 0) ? 1'b1 : 1'($urandom);
      tick();
      chk("hold_data", bus.result_data, held);
      chk("hold_valid", 128'(bus.out_valid), 128'(1));
      chk("hold_busy", 128'(bus.busy), 128'(0));
    end
    bus.in_valid = 1'b0;

    // back-to-back: start together with the handshake
    bus.start = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    model_clear();
    chk("b2b_busy", 128'(bus.busy), 128'(1));
    chk("b2b_valid_low", 128'(bus.out_valid), 128'(0));
    chk("b2b_cleared", bus.result_data, 128'(0));
    feed({8{16'hC3C3}}, 0, 16'h0, edges);
    chk("b2b_latency", 128'(edges + 1), 128'(17));
    chk("b2b_words", bus.result_data, model_flat());
    handshake();

    // reset mid-packet
    do_start();
    for (int i = 0; i < 7; i++) begin
      drive_beat(pkt1, i);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("mid_counter", 128'(bus.bit_counter), 128'(7));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 128'(bus.busy), 128'(0));
    chk("mid_rst_counter", 128'(bus.bit_counter), 128'(0));
    chk("mid_rst_data", bus.result_data, 128'(0));
    chk("mid_rst_valid", 128'(bus.out_valid), 128'(0));
    do_start();
    feed({8{16'h00FF}}, 0, 16'h0, edges);
    chk("after_rst_words", bus.result_data, 128'({8{16'h00FF}}));
    handshake();

    // start during COLLECT must not restart
    do_start();
    for (int i = 0; i < 5; i++) begin
      drive_beat(pkt1, i);
      tick();
    end
    bus.start = 1'b1;
    drive_beat(pkt1, 5);
    tick();
    bus.start = 1'b0;
    chk("collect_start_counter", 128'(bus.bit_counter), 128'(6));
    chk("collect_start_busy", 128'(bus.busy), 128'(1));
    feed(pkt1, 6, 16'h0, edges);
    chk("collect_start_words", bus.result_data, model_flat());
    chk("collect_start_table", bus.result_data, pkt1);
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
